// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: one half double-round per cycle over 4 parallel quarter rounds.
// Optional build macro CHACHA_ZEROIZE_EN clears key material and keystream after each handshake.
module chacha_block_core #(
    parameter int unsigned ROUNDS = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [31:0]  counter,
    input  logic [95:0]  nonce,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [511:0] keystream
);

    if ((ROUNDS < 2) || (ROUNDS > 20) || ((ROUNDS % 2) != 0)) begin : gen_bad_rounds
        $error("chacha_block_core: ROUNDS must be even and within 2..20");
    end

    typedef enum logic [1:0] {StIdle, StRound, StFinal, StDone} state_e;

    state_e            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [15:0][31:0] init_q, init_d;
    logic [15:0][31:0] work_q, work_d;
    logic [15:0][31:0] ks_q, ks_d;
    logic [15:0][31:0] init_st;
    logic [15:0][31:0] round_st;

    function automatic logic [127:0] qr(input logic [31:0] a_in, input logic [31:0] b_in,
                                        input logic [31:0] c_in, input logic [31:0] d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {d, c, b, a};
    endfunction

    // Word 15 sits in the top bits, so the concatenation reads nonce-first.
    assign init_st = {nonce, counter, key, 128'h6b206574_79622d32_3320646e_61707865};

    // Even counter: column rounds; odd counter: diagonal rounds.
    always_comb begin
        round_st = work_q;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] ia, ib, ic, id;
            ia = 4'(i);
            if (!cnt_q[0]) begin
                ib = 4'(4 + i);
                ic = 4'(8 + i);
                id = 4'(12 + i);
            end else begin
                ib = 4'(4 + ((i + 1) % 4));
                ic = 4'(8 + ((i + 2) % 4));
                id = 4'(12 + ((i + 3) % 4));
            end
            {round_st[id], round_st[ic], round_st[ib], round_st[ia]} =
                qr(work_q[ia], work_q[ib], work_q[ic], work_q[id]);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_d  = init_q;
        work_d  = work_q;
        ks_d    = ks_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    init_d  = init_st;
                    work_d  = init_st;
                    cnt_d   = '0;
                    state_d = StRound;
                end
            end
            StRound: begin
                work_d = round_st;
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'(ROUNDS - 1)) begin
                    state_d = StFinal;
                end
            end
            StFinal: begin
                for (int i = 0; i < 16; i++) begin
                    ks_d[4'(i)] = work_q[4'(i)] + init_q[4'(i)];
                end
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
`ifdef CHACHA_ZEROIZE_EN
                    init_d = '0;
                    work_d = '0;
                    ks_d   = '0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            init_q  <= '0;
            work_q  <= '0;
            ks_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= init_d;
            work_q  <= work_d;
            ks_q    <= ks_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign keystream = ks_q;

endmodule

// File: tb/tb_chacha_block_core.sv
// Self-checking bench for chacha_block_core: RFC vectors, handshake timing and a behavioural model.
module tb_chacha_block_core;

    localparam int unsigned ROUNDS = 20;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] key;
    logic [31:0]  counter;
    logic [95:0]  nonce;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] keystream;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    chacha_block_core #(.ROUNDS(ROUNDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key       (key),
        .counter   (counter),
        .nonce     (nonce),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .keystream (keystream)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rotl(input logic [31:0] v, input int r);
        return (v << r) | (v >> (32 - r));
    endfunction

    // Reference block function written straight from the ChaCha definition.
    function automatic logic [511:0] ref_block(input logic [255:0] k, input logic [31:0] c,
                                               input logic [95:0] n);
        logic [31:0] s[16];
        logic [31:0] x[16];
        logic [511:0] r;
        int qi[8][4];
        int a, b, cc, d;
        qi = '{'{0, 4, 8, 12}, '{1, 5, 9, 13}, '{2, 6, 10, 14}, '{3, 7, 11, 15},
               '{0, 5, 10, 15}, '{1, 6, 11, 12}, '{2, 7, 8, 13}, '{3, 4, 9, 14}};
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = k[32 * i +: 32];
        s[12] = c;
        for (int j = 0; j < 3; j++) s[13 + j] = n[32 * j +: 32];
        x = s;
        for (int dr = 0; dr < int'(ROUNDS / 2); dr++) begin
            for (int q = 0; q < 8; q++) begin
                a = qi[q][0]; b = qi[q][1]; cc = qi[q][2]; d = qi[q][3];
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
                x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 12);
                x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
                x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 7);
            end
        end
        for (int i = 0; i < 16; i++) r[32 * i +: 32] = x[i] + s[i];
        return r;
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32 * i +: 32] = $urandom;
        return k;
    endfunction

    // Drive a request and return once it has been accepted (t_acc: cycle of acceptance).
    task automatic start_req(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n,
                             output int t_acc, output bit ok);
        int w;
        @(negedge clk);
        key = k; counter = c; nonce = n; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        ok = in_ready;
        t_acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        key = '0; counter = '0; nonce = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || keystream !== '0) begin
            errors++;
            $display("FAIL reset_in: in_ready=%b out_valid=%b ks=%h, want 1 0 0",
                     in_ready, out_valid, keystream);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || keystream !== '0) begin
            errors++;
            $display("FAIL reset_out: in_ready=%b out_valid=%b ks=%h, want 1 0 0",
                     in_ready, out_valid, keystream);
        end
    endtask

    task automatic test_rfc_vector();
        logic [255:0] k;
        logic [31:0] exp_w[8];
        int idx[8];
        int t, lat;
        bit ok;
        for (int b = 0; b < 32; b++) k[8 * b +: 8] = 8'(b);
        exp_w = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3,
                  32'hd19c12b5, 32'hb94e16de, 32'he883d0cb, 32'h4e3c50a2};
        idx = '{0, 1, 2, 3, 12, 13, 14, 15};
        start_req(k, 32'd1, {32'h00000000, 32'h4a000000, 32'h09000000}, t, ok);
        wait_out(lat);
        checks++;
        if (!ok || lat != int'(ROUNDS + 1)) begin
            errors++;
            $display("FAIL rfc_latency: accepted=%0b latency=%0d, want 1 %0d", ok, lat, ROUNDS + 1);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (keystream[32 * idx[i] +: 32] !== exp_w[i]) begin
                errors++;
                $display("FAIL rfc_word%0d: got %h want %h", idx[i],
                         keystream[32 * idx[i] +: 32], exp_w[i]);
            end
        end
        handshake();
    endtask

    task automatic test_zero_key();
        int t, lat;
        bit ok;
        logic [511:0] exp;
        exp = ref_block('0, '0, '0);
        start_req('0, '0, '0, t, ok);
        wait_out(lat);
        checks++;
        if (out_valid !== 1'b1 || keystream[31:0] !== 32'hade0b876
            || keystream[63:32] !== 32'h903df1a0) begin
            errors++;
            $display("FAIL zero_words01: valid=%b w0=%h w1=%h, want 1 ade0b876 903df1a0",
                     out_valid, keystream[31:0], keystream[63:32]);
        end
        checks++;
        if (keystream !== exp) begin
            errors++;
            $display("FAIL zero_block: got %h want %h", keystream, exp);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        logic [255:0] k;
        logic [31:0] c;
        logic [95:0] n;
        logic [511:0] exp;
        int t, lat;
        bit ok;
        k = rand_key(); c = $urandom; n = {$urandom, $urandom, $urandom};
        exp = ref_block(k, c, n);
        start_req(k, c, n, t, ok);
        wait_out(lat);
        checks++;
        if (keystream !== exp) begin
            errors++;
            $display("FAIL bp_block: got %h want %h", keystream, exp);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (keystream !== exp || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: valid=%b in_ready=%b ks=%h, want 1 0 %h",
                         i, out_valid, in_ready, keystream, exp);
            end
        end
        handshake();
`ifdef CHACHA_ZEROIZE_EN
        exp = '0;
`endif
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || keystream !== exp) begin
            errors++;
            $display("FAIL bp_after: in_ready=%b valid=%b ks=%h, want 1 0 %h",
                     in_ready, out_valid, keystream, exp);
        end
    endtask

    task automatic test_busy_reject();
        logic [255:0] ka, kb;
        logic [31:0] c;
        logic [95:0] n;
        logic [511:0] exp;
        int t, lat;
        bit ok;
        ka = rand_key(); kb = ~ka; c = $urandom; n = {$urandom, $urandom, $urandom};
        exp = ref_block(ka, c, n);
        start_req(ka, c, n, t, ok);
        repeat (3) @(negedge clk);
        key = kb; in_valid = 1'b1;
        @(negedge clk);
        key = ka; in_valid = 1'b0;
        wait_out(lat);
        checks++;
        if (out_valid !== 1'b1 || keystream !== exp) begin
            errors++;
            $display("FAIL busy_reject: valid=%b got %h want %h", out_valid, keystream, exp);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        logic [255:0] k;
        logic [31:0] c;
        logic [95:0] n;
        logic [511:0] exp;
        int t, lat;
        bit ok;
        k = rand_key(); c = $urandom; n = {$urandom, $urandom, $urandom};
        start_req(k, c, n, t, ok);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || keystream !== '0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort: valid=%b ks=%h in_ready=%b, want 0 0 1",
                     out_valid, keystream, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        k = rand_key(); c = $urandom; n = {$urandom, $urandom, $urandom};
        exp = ref_block(k, c, n);
        start_req(k, c, n, t, ok);
        wait_out(lat);
        checks++;
        if (lat != int'(ROUNDS + 1) || keystream !== exp) begin
            errors++;
            $display("FAIL post_abort: latency=%0d got %h want %0d %h", lat, keystream,
                     ROUNDS + 1, exp);
        end
        handshake();
    endtask

    task automatic test_back_to_back();
        logic [255:0] k;
        logic [95:0] n;
        logic [511:0] exp1, exp2, after;
        int t1, t2, lat, w;
        k = rand_key(); n = {$urandom, $urandom, $urandom};
        exp1 = ref_block(k, 32'hffffffff, n);
        exp2 = ref_block(k, 32'h00000000, n);
        out_ready = 1'b1;
        @(negedge clk);
        key = k; nonce = n; counter = 32'hffffffff; in_valid = 1'b1;
        t1 = cyc;
        @(negedge clk);
        counter = 32'h0;
        wait_out(lat);
        checks++;
        if (keystream !== exp1) begin
            errors++;
            $display("FAIL b2b_block1: got %h want %h", keystream, exp1);
        end
        @(negedge clk);
`ifdef CHACHA_ZEROIZE_EN
        after = '0;
`else
        after = exp1;
`endif
        checks++;
        if (keystream !== after || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_after1: valid=%b ks=%h, want 0 %h", out_valid, keystream, after);
        end
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        t2 = cyc;
        checks++;
        if (t2 - t1 != int'(ROUNDS + 3)) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles want %0d", t2 - t1, ROUNDS + 3);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        checks++;
        if (keystream !== exp2) begin
            errors++;
            $display("FAIL b2b_block2: got %h want %h", keystream, exp2);
        end
        @(negedge clk);
        out_ready = 1'b0;
`ifdef CHACHA_ZEROIZE_EN
        after = '0;
`else
        after = exp2;
`endif
        checks++;
        if (keystream !== after || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_after2: in_ready=%b ks=%h, want 1 %h", in_ready, keystream, after);
        end
    endtask

    task automatic test_random();
        logic [255:0] k;
        logic [31:0] c;
        logic [95:0] n;
        logic [511:0] exp;
        int t, lat;
        bit ok;
        for (int r = 0; r < 4; r++) begin
            k = rand_key(); c = $urandom; n = {$urandom, $urandom, $urandom};
            exp = ref_block(k, c, n);
            start_req(k, c, n, t, ok);
            wait_out(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || keystream !== exp) begin
                errors++;
                $display("FAIL random%0d: valid=%b got %h want %h", r, out_valid, keystream, exp);
            end
            handshake();
        end
    endtask

    initial begin
        test_reset();
        test_rfc_vector();
        test_zero_key();
        test_backpressure();
        test_busy_reject();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
